// File: rtl/uart_pkg.sv
// Shared types and helpers for the parametrised UART core.
package uart_pkg;

    typedef enum logic [1:0] {
        PAR_NONE = 2'd0,
        PAR_ODD  = 2'd1,
        PAR_EVEN = 2'd2
    } parity_e;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_PARITY,
        TX_STOP
    } tx_state_e;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP,
        RX_WAIT_HIGH
    } rx_state_e;

    localparam int RX_FIFO_DEPTH = 4;

    // Rounded clock cycles per bit.
    function automatic int baud_div(input int clk_freq, input int baudrate);
        return (clk_freq + baudrate / 2) / baudrate;
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through RX FIFO; used by uart_core when UART_RX_FIFO_EN is defined.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int WIDTH = 9
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             empty_o,
    output logic             full_o
);

    localparam int AW = $clog2(RX_FIFO_DEPTH);

    logic [WIDTH-1:0] r_mem [RX_FIFO_DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic             w_do_push;
    logic             w_do_pop;

    assign empty_o   = (r_wr_ptr == r_rd_ptr);
    assign full_o    = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_do_pop  = pop_i && !empty_o;
    // A push into a full FIFO is only legal when the head leaves in the same cycle.
    assign w_do_push = push_i && (!full_o || w_do_pop);
    assign data_o    = r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            for (int i = 0; i < RX_FIFO_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr[AW-1:0]] <= data_i;
                r_wr_ptr                <= r_wr_ptr + (AW+1)'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/uart_core.sv
// Parametrised full-duplex UART with valid/ready byte interfaces and error flags.
// Define UART_RX_FIFO_EN to replace the RX holding register with a 4-entry FIFO.
module uart_core
    import uart_pkg::*;
#(
    parameter int CLK_FREQ  = 40000000,
    parameter int BAUDRATE  = 115200,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 rx_i,
    output logic                 tx_o,
    input  logic [DATA_BITS-1:0] tx_data_i,
    input  logic                 tx_valid_i,
    output logic                 tx_ready_o,
    output logic [DATA_BITS-1:0] rx_data_o,
    output logic                 rx_valid_o,
    input  logic                 rx_ready_i,
    output logic                 rx_parity_err_o,
    output logic                 frame_err_o,
    output logic                 overrun_o
);

    localparam int      DIV         = baud_div(CLK_FREQ, BAUDRATE);
    localparam int      HALF        = DIV / 2;
    localparam int      CW          = $clog2(DIV + 1);
    localparam logic [CW-1:0] BIT_RELOAD  = CW'(DIV - 1);
    localparam logic [CW-1:0] HALF_RELOAD = CW'(HALF - 1);
    localparam logic [2:0]    LAST_DATA   = 3'(DATA_BITS - 1);
    localparam logic [2:0]    LAST_STOP   = 3'(STOP_BITS - 1);
    localparam parity_e PAR_MODE = (PARITY == 1) ? PAR_ODD : (PARITY == 2) ? PAR_EVEN : PAR_NONE;
    localparam bit      PAR_EN   = (PARITY != 0);

    if (DIV < 4 || DATA_BITS < 5 || DATA_BITS > 8 || PARITY < 0 || PARITY > 2 ||
        STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_param
        $error("uart_core: illegal parameter set");
    end

    // state        | meaning
    // TX_IDLE      | line high, ready for a byte
    // TX_START     | driving the start bit
    // TX_DATA      | shifting data bits out LSB first
    // TX_PARITY    | driving the parity bit
    // TX_STOP      | driving STOP_BITS stop bits
    // RX_IDLE      | waiting for a falling edge
    // RX_START     | half-bit wait, glitch rejection
    // RX_DATA      | sampling data bits mid-bit
    // RX_PARITY    | sampling the parity bit
    // RX_STOP      | sampling the first stop bit
    // RX_WAIT_HIGH | framing error seen, waiting for line to return high

    tx_state_e            r_tx_state;
    logic [CW-1:0]        r_tx_cnt;
    logic [2:0]           r_tx_bit;
    logic [DATA_BITS-1:0] r_tx_shift;
    logic                 r_tx_par;
    logic                 r_tx;
    logic                 r_tx_ready;

    assign tx_o       = r_tx;
    assign tx_ready_o = r_tx_ready;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_tx_state <= TX_IDLE;
            r_tx_cnt   <= '0;
            r_tx_bit   <= '0;
            r_tx_shift <= '0;
            r_tx_par   <= 1'b0;
            r_tx       <= 1'b1;
            r_tx_ready <= 1'b1;
        end else begin
            case (r_tx_state)
                TX_IDLE: begin
                    r_tx       <= 1'b1;
                    r_tx_ready <= 1'b1;
                    if (tx_valid_i && r_tx_ready) begin
                        r_tx_shift <= tx_data_i;
                        r_tx_par   <= (PAR_MODE == PAR_ODD) ? ~^tx_data_i : ^tx_data_i;
                        r_tx       <= 1'b0;
                        r_tx_ready <= 1'b0;
                        r_tx_cnt   <= BIT_RELOAD;
                        r_tx_state <= TX_START;
                    end
                end
                TX_START: begin
                    if (r_tx_cnt == '0) begin
                        r_tx       <= r_tx_shift[0];
                        r_tx_shift <= r_tx_shift >> 1;
                        r_tx_bit   <= '0;
                        r_tx_cnt   <= BIT_RELOAD;
                        r_tx_state <= TX_DATA;
                    end else begin
                        r_tx_cnt <= r_tx_cnt - CW'(1);
                    end
                end
                TX_DATA: begin
                    if (r_tx_cnt == '0) begin
                        r_tx_cnt <= BIT_RELOAD;
                        if (r_tx_bit == LAST_DATA) begin
                            r_tx_bit <= '0;
                            if (PAR_EN) begin
                                r_tx       <= r_tx_par;
                                r_tx_state <= TX_PARITY;
                            end else begin
                                r_tx       <= 1'b1;
                                r_tx_state <= TX_STOP;
                            end
                        end else begin
                            r_tx       <= r_tx_shift[0];
                            r_tx_shift <= r_tx_shift >> 1;
                            r_tx_bit   <= r_tx_bit + 3'd1;
                        end
                    end else begin
                        r_tx_cnt <= r_tx_cnt - CW'(1);
                    end
                end
                TX_PARITY: begin
                    if (r_tx_cnt == '0) begin
                        r_tx       <= 1'b1;
                        r_tx_bit   <= '0;
                        r_tx_cnt   <= BIT_RELOAD;
                        r_tx_state <= TX_STOP;
                    end else begin
                        r_tx_cnt <= r_tx_cnt - CW'(1);
                    end
                end
                TX_STOP: begin
                    if (r_tx_cnt == '0) begin
                        if (r_tx_bit == LAST_STOP) begin
                            r_tx_ready <= 1'b1;
                            r_tx_state <= TX_IDLE;
                        end else begin
                            r_tx_bit <= r_tx_bit + 3'd1;
                            r_tx_cnt <= BIT_RELOAD;
                        end
                    end else begin
                        r_tx_cnt <= r_tx_cnt - CW'(1);
                    end
                end
                default: begin
                    r_tx       <= 1'b1;
                    r_tx_state <= TX_IDLE;
                end
            endcase
        end
    end

    logic [1:0]           r_rx_sync;
    logic                 w_rx;
    rx_state_e            r_rx_state;
    logic [CW-1:0]        r_rx_cnt;
    logic [2:0]           r_rx_bit;
    logic [DATA_BITS-1:0] r_rx_shift;
    logic                 r_rx_par;
    logic                 r_rx_perr;
    logic                 r_frame_err;
    logic                 w_deliver;
    logic                 w_rx_perr;

    assign w_rx        = r_rx_sync[1];
    assign w_deliver   = (r_rx_state == RX_STOP) && (r_rx_cnt == '0) && w_rx;
    assign w_rx_perr   = PAR_EN ? r_rx_perr : 1'b0;
    assign frame_err_o = r_frame_err;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rx_sync <= 2'b11;
        end else begin
            r_rx_sync <= {r_rx_sync[0], rx_i};
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rx_state  <= RX_IDLE;
            r_rx_cnt    <= '0;
            r_rx_bit    <= '0;
            r_rx_shift  <= '0;
            r_rx_par    <= 1'b0;
            r_rx_perr   <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_frame_err <= 1'b0;
            case (r_rx_state)
                RX_IDLE: begin
                    if (!w_rx) begin
                        r_rx_cnt   <= HALF_RELOAD;
                        r_rx_state <= RX_START;
                    end
                end
                RX_START: begin
                    if (r_rx_cnt == '0) begin
                        if (w_rx) begin
                            r_rx_state <= RX_IDLE;
                        end else begin
                            r_rx_cnt   <= BIT_RELOAD;
                            r_rx_bit   <= '0;
                            r_rx_par   <= 1'b0;
                            r_rx_perr  <= 1'b0;
                            r_rx_state <= RX_DATA;
                        end
                    end else begin
                        r_rx_cnt <= r_rx_cnt - CW'(1);
                    end
                end
                RX_DATA: begin
                    if (r_rx_cnt == '0) begin
                        r_rx_shift <= {w_rx, r_rx_shift[DATA_BITS-1:1]};
                        r_rx_par   <= r_rx_par ^ w_rx;
                        r_rx_cnt   <= BIT_RELOAD;
                        if (r_rx_bit == LAST_DATA) begin
                            r_rx_state <= PAR_EN ? RX_PARITY : RX_STOP;
                        end else begin
                            r_rx_bit <= r_rx_bit + 3'd1;
                        end
                    end else begin
                        r_rx_cnt <= r_rx_cnt - CW'(1);
                    end
                end
                RX_PARITY: begin
                    if (r_rx_cnt == '0) begin
                        r_rx_perr  <= (PAR_MODE == PAR_ODD) ? ~(w_rx ^ r_rx_par) : (w_rx ^ r_rx_par);
                        r_rx_cnt   <= BIT_RELOAD;
                        r_rx_state <= RX_STOP;
                    end else begin
                        r_rx_cnt <= r_rx_cnt - CW'(1);
                    end
                end
                RX_STOP: begin
                    if (r_rx_cnt == '0) begin
                        if (w_rx) begin
                            r_rx_state <= RX_IDLE;
                        end else begin
                            r_frame_err <= 1'b1;
                            r_rx_state  <= RX_WAIT_HIGH;
                        end
                    end else begin
                        r_rx_cnt <= r_rx_cnt - CW'(1);
                    end
                end
                RX_WAIT_HIGH: begin
                    if (w_rx) begin
                        r_rx_state <= RX_IDLE;
                    end
                end
                default: r_rx_state <= RX_IDLE;
            endcase
        end
    end

    logic r_overrun;
    assign overrun_o = r_overrun;

`ifdef UART_RX_FIFO_EN
    logic               w_fifo_empty;
    logic               w_fifo_full;
    logic               w_pop;
    logic [DATA_BITS:0] w_fifo_rdata;

    assign w_pop           = !w_fifo_empty && rx_ready_i;
    assign rx_valid_o      = !w_fifo_empty;
    assign rx_data_o       = w_fifo_rdata[DATA_BITS-1:0];
    assign rx_parity_err_o = w_fifo_rdata[DATA_BITS];

    uart_rx_fifo #(
        .WIDTH (DATA_BITS + 1)
    ) u_rx_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (w_deliver),
        .data_i  ({w_rx_perr, r_rx_shift}),
        .pop_i   (w_pop),
        .data_o  (w_fifo_rdata),
        .empty_o (w_fifo_empty),
        .full_o  (w_fifo_full)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_overrun <= 1'b0;
        end else begin
            r_overrun <= w_deliver && w_fifo_full && !w_pop;
        end
    end
`else
    logic [DATA_BITS-1:0] r_rx_data;
    logic                 r_rx_valid;
    logic                 r_rx_perr_hold;

    assign rx_valid_o      = r_rx_valid;
    assign rx_data_o       = r_rx_data;
    assign rx_parity_err_o = r_rx_perr_hold;

    // A consume in the delivery cycle frees the register, so the new byte wins.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rx_data      <= '0;
            r_rx_valid     <= 1'b0;
            r_rx_perr_hold <= 1'b0;
            r_overrun      <= 1'b0;
        end else begin
            r_overrun <= 1'b0;
            if (w_deliver) begin
                if (r_rx_valid && !rx_ready_i) begin
                    r_overrun <= 1'b1;
                end else begin
                    r_rx_data      <= r_rx_shift;
                    r_rx_perr_hold <= w_rx_perr;
                    r_rx_valid     <= 1'b1;
                end
            end else if (r_rx_valid && rx_ready_i) begin
                r_rx_valid <= 1'b0;
            end
        end
    end
`endif

endmodule

// File: tb/tb_uart_core.sv
// Directed self-checking bench for uart_core at DIV=10, 8 data bits, even parity, 1 stop bit.
module tb_uart_core;

    localparam int DIV = 10;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx_drv = 1'b1;
    logic       loop_en = 1'b0;
    logic       rx_line;
    logic       tx_o;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready = 1'b0;
    logic       rx_perr;
    logic       ferr;
    logic       ovr;

    int n_checks = 0;
    int n_fail   = 0;
    int n_ferr   = 0;
    int n_ovr    = 0;
    int n_rx     = 0;
    logic [7:0] last_data = 8'h00;
    logic       last_perr = 1'b0;

    assign rx_line = loop_en ? tx_o : rx_drv;

    always #5 clk = ~clk;

    uart_core #(
        .CLK_FREQ  (1000000),
        .BAUDRATE  (100000),
        .DATA_BITS (8),
        .PARITY    (2),
        .STOP_BITS (1)
    ) dut (
        .clk_i           (clk),
        .rst_ni          (rst_n),
        .rx_i            (rx_line),
        .tx_o            (tx_o),
        .tx_data_i       (tx_data),
        .tx_valid_i      (tx_valid),
        .tx_ready_o      (tx_ready),
        .rx_data_o       (rx_data),
        .rx_valid_o      (rx_valid),
        .rx_ready_i      (rx_ready),
        .rx_parity_err_o (rx_perr),
        .frame_err_o     (ferr),
        .overrun_o       (ovr)
    );

    always @(negedge clk) begin
        if (ferr) n_ferr++;
        if (ovr) n_ovr++;
        if (rx_valid && rx_ready) begin
            n_rx++;
            last_data = rx_data;
            last_perr = rx_perr;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Drives one frame on rx_drv from a negedge; line returns high afterwards.
    task automatic send_rx(input logic [7:0] d, input logic pbit, input logic sbit);
        logic [10:0] bits;
        bits = {sbit, pbit, d, 1'b0};
        for (int i = 0; i < 11; i++) begin
            rx_drv = bits[i];
            repeat (DIV) @(negedge clk);
        end
        rx_drv = 1'b1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [10:0] exp_frame;
        logic [7:0]  exp_fifo [5];
        int          bad, n0, f0, o0;

        repeat (3) @(negedge clk);
        check("rst_tx_o", tx_o, 1);
        check("rst_tx_ready", tx_ready, 1);
        check("rst_rx_valid", rx_valid, 0);
        check("rst_rx_data", rx_data, 0);
        check("rst_perr", rx_perr, 0);
        check("rst_ferr", ferr, 0);
        check("rst_ovr", ovr, 0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // TX 0xA5: start 0, data 1,0,1,0,0,1,0,1, parity 0, stop 1 (bit0 = start).
        exp_frame = 11'h54A;
        bad = 0;
        tx_data = 8'hA5;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        for (int c = 1; c <= 111; c++) begin
            if (c <= 110) begin
                if (tx_o !== exp_frame[(c-1)/DIV]) bad++;
                if ((c - 1) % DIV == 5) check($sformatf("tx_a5_bit%0d", (c-1)/DIV), tx_o, exp_frame[(c-1)/DIV]);
            end
            if (c == 110) check("tx_ready_busy_end", tx_ready, 0);
            if (c == 111) check("tx_ready_back", tx_ready, 1);
            if (c == 50) begin tx_data = 8'hFF; tx_valid = 1'b1; end
            if (c == 60) tx_valid = 1'b0;
            @(negedge clk);
        end
        check("tx_a5_stable", bad, 0);
        check("tx_idle_after", tx_o, 1);

        // Loopback 0x3C.
        rx_ready = 1'b1;
        loop_en = 1'b1;
        n0 = n_rx; f0 = n_ferr;
        tx_data = 8'h3C;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        for (int i = 0; i < 300 && n_rx == n0; i++) @(negedge clk);
        check("lb_rx_count", n_rx - n0, 1);
        check("lb_rx_data", last_data, 8'h3C);
        check("lb_rx_perr", last_perr, 0);
        repeat (20) @(negedge clk);
        check("lb_ferr", n_ferr - f0, 0);
        check("lb_tx_ready", tx_ready, 1);
        loop_en = 1'b0;

        // Three-cycle glitch is rejected.
        n0 = n_rx; f0 = n_ferr;
        rx_drv = 1'b0;
        repeat (3) @(negedge clk);
        rx_drv = 1'b1;
        repeat (40) @(negedge clk);
        check("glitch_no_rx", n_rx - n0, 0);
        check("glitch_no_ferr", n_ferr - f0, 0);

        // Framing error with break, then a good 0x55.
        send_rx(8'h00, 1'b0, 1'b0);
        rx_drv = 1'b0;
        repeat (50) @(negedge clk);
        rx_drv = 1'b1;
        repeat (20) @(negedge clk);
        check("ferr_pulse", n_ferr - f0, 1);
        check("ferr_no_rx", n_rx - n0, 0);
        send_rx(8'h55, 1'b0, 1'b1);
        repeat (10) @(negedge clk);
        check("after_brk_count", n_rx - n0, 1);
        check("after_brk_data", last_data, 8'h55);
        check("after_brk_perr", last_perr, 0);
        check("after_brk_ferr", n_ferr - f0, 1);

        // 0x01 needs parity 1 under even parity; send 0.
        send_rx(8'h01, 1'b0, 1'b1);
        repeat (10) @(negedge clk);
        check("perr_data", last_data, 8'h01);
        check("perr_flag", last_perr, 1);

        // Overrun.
        rx_ready = 1'b0;
        o0 = n_ovr;
`ifdef UART_RX_FIFO_EN
        exp_fifo[0] = 8'h11; exp_fifo[1] = 8'h22; exp_fifo[2] = 8'h33;
        exp_fifo[3] = 8'h44; exp_fifo[4] = 8'h55;
        for (int i = 0; i < 5; i++) send_rx(exp_fifo[i], ^exp_fifo[i], 1'b1);
        repeat (10) @(negedge clk);
        check("ovr_pulse", n_ovr - o0, 1);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("fifo_valid%0d", i), rx_valid, 1);
            check($sformatf("fifo_data%0d", i), rx_data, exp_fifo[i]);
            rx_ready = 1'b1;
            @(negedge clk);
            rx_ready = 1'b0;
        end
        check("fifo_empty", rx_valid, 0);
`else
        exp_fifo[0] = 8'h11; exp_fifo[1] = 8'h22;
        for (int i = 0; i < 2; i++) send_rx(exp_fifo[i], ^exp_fifo[i], 1'b1);
        repeat (10) @(negedge clk);
        check("ovr_pulse", n_ovr - o0, 1);
        check("ovr_valid", rx_valid, 1);
        check("ovr_keep_old", rx_data, 8'h11);
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
        check("consume_clears", rx_valid, 0);
`endif

        // Held byte, then reset in the middle of a looped-back TX frame.
        send_rx(8'h66, 1'b0, 1'b1);
        repeat (10) @(negedge clk);
        check("held_valid", rx_valid, 1);
        check("held_data", rx_data, 8'h66);
        loop_en = 1'b1;
        tx_data = 8'h00;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        repeat (35) @(negedge clk);
        check("midtx_tx_low", tx_o, 0);
        check("midtx_busy", tx_ready, 0);
        rst_n = 1'b0;
        #1;
        check("rst_mid_tx_o", tx_o, 1);
        check("rst_mid_ready", tx_ready, 1);
        check("rst_mid_rx_valid", rx_valid, 0);
        check("rst_mid_rx_data", rx_data, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (150) @(negedge clk);
        check("post_rst_no_rx", rx_valid, 0);
        check("post_rst_tx_idle", tx_o, 1);
        loop_en = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
